// File: rtl/zion_basic_circuit_lib_pkg.sv
// Shared types and constants for the zion basic circuit library.
// Used by the clearable skid register (see CLR_SKID_DROP_CNT_EN in its top file).
package zion_basic_circuit_lib_pkg;

  typedef enum logic [1:0] {SKID_EMPTY, SKID_HALF, SKID_FULL} skid_state_t;

  localparam int unsigned SKID_DEPTH = 2;

  // Number of beats held by the skid stage in a given state.
  function automatic logic [1:0] skid_occupancy(input skid_state_t s);
    logic [1:0] occ;
    occ = '0;
    case (s)
      SKID_HALF: occ = 2'd1;
      SKID_FULL: occ = 2'(SKID_DEPTH);
      default:   occ = '0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/zion_basic_circuit_lib_clr_skid_reg_if.sv
// Valid/ready handshake bundle for the clearable skid register.
// slave = the skid stage itself, master = the surrounding producer/consumer.
interface zion_basic_circuit_lib_clr_skid_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             iClr;
  logic             iVld;
  logic             oRdy;
  logic [WIDTH-1:0] iDat;
  logic             oVld;
  logic             iRdy;
  logic [WIDTH-1:0] oDat;

  modport master (
    output iClr, iVld, iDat, iRdy,
    input  oRdy, oVld, oDat
  );

  modport slave (
    input  iClr, iVld, iDat, iRdy,
    output oRdy, oVld, oDat
  );
endinterface

// File: rtl/zion_basic_circuit_lib_clr_skid_ctrl.sv
// Control path of the clearable skid register: 3-state occupancy FSM,
// registered oVld/oRdy, data-register load enables, clear priority and,
// with CLR_SKID_DROP_CNT_EN defined, the saturating dropped-beat counter.
module zion_basic_circuit_lib_clr_skid_ctrl
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  vld_in,
  input  logic                  rdy_in,
  output logic                  vld_out,
  output logic                  rdy_out,
  output logic                  main_ld_in,
  output logic                  main_ld_skid,
  output logic                  main_ini,
  output logic                  skid_ld_in,
  output logic                  skid_ini
`ifdef CLR_SKID_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  skid_state_t state_q, state_d;
  logic        vld_q, vld_d;
  logic        rdy_q, rdy_d;
  logic        in_fire, out_fire;

  assign in_fire  = vld_in & rdy_q;
  assign out_fire = vld_q & rdy_in;
  assign vld_out  = vld_q;
  assign rdy_out  = rdy_q;

  // Next state and data-register enables; clear overrides every transition.
  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    main_ini     = 1'b0;
    skid_ld_in   = 1'b0;
    skid_ini     = 1'b0;
    if (clr) begin
      state_d  = SKID_EMPTY;
      main_ini = 1'b1;
      skid_ini = 1'b1;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (in_fire) begin
            state_d    = SKID_HALF;
            main_ld_in = 1'b1;
          end
        end
        SKID_HALF: begin
          if (in_fire && out_fire) begin
            main_ld_in = 1'b1;
          end else if (in_fire) begin
            state_d    = SKID_FULL;
            skid_ld_in = 1'b1;
          end else if (out_fire) begin
            state_d  = SKID_EMPTY;
            main_ini = 1'b1;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            state_d      = SKID_HALF;
            main_ld_skid = 1'b1;
            skid_ini     = 1'b1;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
    // Handshake outputs are flops decoded from the next state, so both
    // directions stay fully registered.
    vld_d = (state_d != SKID_EMPTY);
    rdy_d = (state_d != SKID_FULL);
  end

  // FSM and handshake flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef CLR_SKID_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]            drop_inc;
  logic [DROP_CNT_W:0]   drop_sum;

  // On a clear, count held beats not leaving this cycle plus any beat accepted.
  always_comb begin
    drop_inc   = skid_occupancy(state_q) - {1'b0, out_fire} + {1'b0, in_fire};
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(drop_inc);
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end

  // Drop counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: rtl/zion_basic_circuit_lib_clr_skid_reg.sv
// Clearable valid/ready register slice with a 2-entry skid buffer.
// Holds the main (output) and skid data registers; control lives in
// zion_basic_circuit_lib_clr_skid_ctrl.
// Optional feature macro: CLR_SKID_DROP_CNT_EN adds the oDropCnt port.
module zion_basic_circuit_lib_clr_skid_reg
  import zion_basic_circuit_lib_pkg::*;
#(
  parameter int unsigned     WIDTH      = 8,
  parameter logic [WIDTH-1:0] INI_DATA  = '0,
  parameter int unsigned     DROP_CNT_W = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  zion_basic_circuit_lib_clr_skid_reg_if.slave bus
`ifdef CLR_SKID_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]             oDropCnt
`endif
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_ld_in, main_ld_skid, main_ini;
  logic             skid_ld_in, skid_ini;

  zion_basic_circuit_lib_clr_skid_ctrl #(
    .DROP_CNT_W (DROP_CNT_W)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (bus.iClr),
    .vld_in       (bus.iVld),
    .rdy_in       (bus.iRdy),
    .vld_out      (bus.oVld),
    .rdy_out      (bus.oRdy),
    .main_ld_in   (main_ld_in),
    .main_ld_skid (main_ld_skid),
    .main_ini     (main_ini),
    .skid_ld_in   (skid_ld_in),
    .skid_ini     (skid_ini)
`ifdef CLR_SKID_DROP_CNT_EN
    ,
    .drop_cnt     (oDropCnt)
`endif
  );

  // Data register next values: clear/drain first, then input, then skid->main.
  always_comb begin
    main_d = main_q;
    if (main_ini)          main_d = INI_DATA;
    else if (main_ld_in)   main_d = bus.iDat;
    else if (main_ld_skid) main_d = skid_q;

    skid_d = skid_q;
    if (skid_ini)          skid_d = INI_DATA;
    else if (skid_ld_in)   skid_d = bus.iDat;
  end

  // Main and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= INI_DATA;
      skid_q <= INI_DATA;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign bus.oDat = main_q;

endmodule

// File: tb/tb_zion_basic_circuit_lib_clr_skid_reg.sv
// Self-checking bench for zion_basic_circuit_lib_clr_skid_reg: a directed
// vector table, an async-reset check, then random traffic against a queue model.
module tb_zion_basic_circuit_lib_clr_skid_reg;

  localparam logic [7:0] INI = 8'h3C;

  logic clk;
  logic rst_n;

  zion_basic_circuit_lib_clr_skid_reg_if #(.WIDTH(8)) bus ();

`ifdef CLR_SKID_DROP_CNT_EN
  logic [1:0] drop_cnt;
`endif

  zion_basic_circuit_lib_clr_skid_reg #(
    .WIDTH      (8),
    .INI_DATA   (INI),
    .DROP_CNT_W (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave)
`ifdef CLR_SKID_DROP_CNT_EN
    ,
    .oDropCnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: FIFO of held beats, capacity 2, plus a saturating drop count.
  logic [7:0]  mq[$];
  int unsigned mcnt = 0;

  function automatic logic m_vld();
    return mq.size() != 0;
  endfunction
  function automatic logic m_rdy();
    return mq.size() < 2;
  endfunction
  function automatic logic [7:0] m_dat();
    return (mq.size() != 0) ? mq[0] : INI;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs at the falling edge, update the model at the rising edge,
  // and return at the next falling edge ready for sampling.
  task automatic step(input logic clr, input logic vld, input logic [7:0] dat, input logic rdy);
    logic in_f, out_f;
    int unsigned held;
    bus.iClr = clr;
    bus.iVld = vld;
    bus.iDat = dat;
    bus.iRdy = rdy;
    in_f  = vld & m_rdy();
    out_f = m_vld() & rdy;
    @(posedge clk);
    if (clr) begin
      held = mq.size();
      mcnt = mcnt + held - (out_f ? 1 : 0) + (in_f ? 1 : 0);
      if (mcnt > 3) mcnt = 3;
      mq.delete();
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f)  mq.push_back(dat);
    end
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".oVld"}, 32'(bus.oVld), 32'(m_vld()));
    chk({tag, ".oRdy"}, 32'(bus.oRdy), 32'(m_rdy()));
    chk({tag, ".oDat"}, 32'(bus.oDat), 32'(m_dat()));
`ifdef CLR_SKID_DROP_CNT_EN
    chk({tag, ".oDropCnt"}, 32'(drop_cnt), mcnt);
`endif
  endtask

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic       ev;
    logic       er;
    logic [7:0] ed;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // clr vld dat rdy | oVld oRdy oDat cnt
    tbl.push_back('{0, 1, 8'h01, 1, 1, 1, 8'h01, 0}); // streaming
    tbl.push_back('{0, 1, 8'h02, 1, 1, 1, 8'h02, 0});
    tbl.push_back('{0, 1, 8'h03, 1, 1, 1, 8'h03, 0});
    tbl.push_back('{0, 1, 8'h04, 1, 1, 1, 8'h04, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 1, INI,   0}); // drain to empty
    tbl.push_back('{0, 1, 8'hA1, 0, 1, 1, 8'hA1, 0}); // backpressure fill
    tbl.push_back('{0, 1, 8'hA2, 0, 1, 0, 8'hA1, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'hA2, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 1, INI,   0});
    tbl.push_back('{0, 1, 8'hB1, 0, 1, 1, 8'hB1, 0}); // clear while full
    tbl.push_back('{0, 1, 8'hB2, 0, 1, 0, 8'hB1, 0});
    tbl.push_back('{1, 1, 8'hB3, 0, 0, 1, INI,   2});
    tbl.push_back('{0, 1, 8'hC1, 0, 1, 1, 8'hC1, 2}); // clear collides with in/out fire
    tbl.push_back('{1, 1, 8'hC2, 1, 0, 1, INI,   3});
    tbl.push_back('{0, 1, 8'hD1, 0, 1, 1, 8'hD1, 3}); // saturation: two more drops
    tbl.push_back('{1, 1, 8'hD2, 0, 0, 1, INI,   3});
    tbl.push_back('{1, 0, 8'h00, 0, 0, 1, INI,   3}); // clear while empty

    rst_n    = 1'b0;
    bus.iClr = 1'b0;
    bus.iVld = 1'b0;
    bus.iDat = 8'h00;
    bus.iRdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.oVld", 32'(bus.oVld), 0);
    chk("rst.oRdy", 32'(bus.oRdy), 1);
    chk("rst.oDat", 32'(bus.oDat), 32'(INI));
    rst_n = 1'b1;
    @(negedge clk);
    step(0, 0, 8'h00, 1);
    chk_model("idle");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].clr, tbl[i].vld, tbl[i].dat, tbl[i].rdy);
      chk($sformatf("tbl%0d.oVld", i), 32'(bus.oVld), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.oRdy", i), 32'(bus.oRdy), 32'(tbl[i].er));
      chk($sformatf("tbl%0d.oDat", i), 32'(bus.oDat), 32'(tbl[i].ed));
`ifdef CLR_SKID_DROP_CNT_EN
      chk($sformatf("tbl%0d.oDropCnt", i), 32'(drop_cnt), 32'(tbl[i].ec));
`endif
    end

    // Asynchronous reset mid-cycle while holding a beat.
    step(0, 1, 8'h55, 0);
    chk("pre_arst.oVld", 32'(bus.oVld), 1);
    bus.iVld = 1'b0;
    bus.iRdy = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.oVld", 32'(bus.oVld), 0);
    chk("arst.oRdy", 32'(bus.oRdy), 1);
    chk("arst.oDat", 32'(bus.oDat), 32'(INI));
`ifdef CLR_SKID_DROP_CNT_EN
    chk("arst.oDropCnt", 32'(drop_cnt), 0);
`endif
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zion_basic_circuit_lib_clr_skid_reg.md
Name: zion_basic_circuit_lib_clr_skid_reg

Overview:
- Valid/ready pipeline register stage with a 2-entry skid buffer and a synchronous clear (flush).
- Sits directly upstream of the library's clearable data registers.
- Decouples producer and consumer timing, fully registered both ways: oVld/oDat and oRdy all come from flops.
- iClr flushes in-flight data in the same cycle a downstream clearable register is cleared, so the pipeline empties coherently.

Parameters:
- WIDTH, 8: data width of iDat/oDat.
- INI_DATA, '0: value of data registers after reset and after clear.
- DROP_CNT_W, 8: width of oDropCnt. Used only with the optional feature.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset. Asynchronous and active-low.
- iClr, input, 1: synchronous clear, active high.
- iVld, input, 1: upstream data valid.
- oRdy, output, 1: ready to upstream. Registered.
- iDat, input, WIDTH: upstream data.
- oVld, output, 1: data valid to downstream. Registered.
- iRdy, input, 1: downstream ready.
- oDat, output, WIDTH: data to downstream. Registered.
- oDropCnt, output, DROP_CNT_W: saturating count of discarded beats. Present only with CLR_SKID_DROP_CNT_EN.

Behaviour:
- Handshakes:
  - in_fire = iVld & oRdy; out_fire = oVld & iRdy.
  - Data moves only on a fire.
  - iVld and iDat must not depend on oRdy within the same cycle.
- Reset (rst_n=0, asynchronous):
  - state=EMPTY, oVld=0, oRdy=1, oDat=INI_DATA, skid reg=INI_DATA, oDropCnt=0.
- Latency: 1 cycle. A beat accepted at edge N is visible on oDat/oVld after edge N when the stage was EMPTY or draining.
- State machine, 3 states (the priority rule below overrides it):
  - EMPTY (oVld=0, oRdy=1):
    - in_fire -> HALF, main<=iDat.
  - HALF (oVld=1, oRdy=1):
    - in_fire & out_fire -> HALF, main<=iDat.
    - in_fire & !out_fire -> FULL, skid<=iDat, oRdy<=0.
    - !in_fire & out_fire -> EMPTY, main<=INI_DATA.
    - otherwise hold.
  - FULL (oVld=1, oRdy=0):
    - out_fire -> HALF, main<=skid, skid<=INI_DATA, oRdy<=1.
    - otherwise hold. in_fire is impossible in this state.
- Priority rule: iClr=1 overrides every transition.
  - Next state EMPTY, main and skid <= INI_DATA, oVld<=0, oRdy<=1.
  - A beat with in_fire=1 in the clear cycle is discarded; the producer still sees it as accepted.
  - An out_fire in the clear cycle completes normally downstream; that beat is not counted as dropped.
- Ordering: strict FIFO, no reordering, no duplication.
- oDat is stable while oVld=1 and iRdy=0.
- Reset mid-operation: contents are lost immediately. No drop counting on reset.

Optional Feature:
- Macro: CLR_SKID_DROP_CNT_EN.
- Defined:
  - oDropCnt port exists.
  - On an iClr cycle it adds (entries held that are not leaving via out_fire) + (1 if in_fire), i.e. 0..3.
  - Saturates at 2^DROP_CNT_W-1.
  - Cleared only by rst_n.
- Undefined: no port, no counter logic.

Decomposition:
- Package zion_basic_circuit_lib_pkg holds:
  - typedef enum logic [1:0] {SKID_EMPTY, SKID_HALF, SKID_FULL} skid_state_t;
  - constant SKID_DEPTH=2.
- One natural sub-module: zion_basic_circuit_lib_clr_skid_ctrl.
  - Contents: the FSM, oRdy/oVld flops, load enables, clear priority, drop-count increment.
  - The top level holds the data registers and the mux from skid to main.

Test Plan:
- Reset, then idle: rst_n low then high, no iVld -> oVld=0, oRdy=1, oDat=INI_DATA; async assert mid-cycle clears immediately.
- Streaming: iRdy=1, iVld=1, iDat=1,2,3,4 on consecutive cycles -> oDat=1,2,3,4 one cycle later, oRdy held at 1, throughput 1/cycle.
- Backpressure fill: iRdy=0, send 0xA1 then 0xA2 -> state FULL, oRdy=0, oDat=0xA1. Then iRdy=1 -> 0xA1 out, then 0xA2 out; oRdy=1 after the first drain.
- Clear while FULL with in_fire not possible: FULL holding 0xB1/0xB2, iClr=1, iRdy=0 -> next cycle oVld=0, oDat=INI_DATA, oRdy=1; oDropCnt += 2 with the feature enabled.
- Clear collisions: HALF holding 0xC1, iClr=1, iVld=1 (0xC2), iRdy=1 in the same cycle -> 0xC1 delivered, 0xC2 discarded, state EMPTY; oDropCnt += 1.
- Counter saturation with DROP_CNT_W=2: issue clears that drop a total of 5 beats -> oDropCnt=3 and stays 3; rst_n -> 0.
